// File: rtl/cla_seq_addsub.sv
// Sequential carry-lookahead adder/subtractor: resolves one 4-bit group per clock,
// ripples a registered carry between groups and accumulates word-level group G/P.
module cla_seq_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             group_g,
    output logic             group_p
);

    localparam int N   = WIDTH / 4;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;
    logic   in_ready_q;

    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [K_W-1:0]   k_q;
    logic             carry_q, g_acc_q, p_acc_q;
    logic             carry_out_q, overflow_q, group_g_q, group_p_q;

    logic             accept;
    logic [3:0]       a_nib, b_nib, p, g, c, sum_nib;
    logic             gk, pk, carry_next, ovf_next, g_next, p_next;
    logic [WIDTH+3:0] res_cat;

    assign accept = in_valid && in_ready_q;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (k_q == K_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
        end
    end

    // Operands are shifted right each CALC cycle, so the active group is always bits [3:0].
    always_comb begin
        a_nib   = a_q[3:0];
        b_nib   = b_q[3:0];
        p       = a_nib | b_nib;
        g       = a_nib & b_nib;
        c[0]    = carry_q;
        c[1]    = g[0] | (p[0] & c[0]);
        c[2]    = g[1] | (p[1] & c[1]);
        c[3]    = g[2] | (p[2] & c[2]);
        sum_nib = a_nib ^ b_nib ^ c;
        gk      = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pk      = &p;
        carry_next = gk | (pk & carry_q);
        ovf_next   = c[3] ^ carry_next;
        g_next     = gk | (pk & g_acc_q);
        p_next     = pk & p_acc_q;
        res_cat    = {sum_nib, result_q};
    end

    // The register set is small, so everything is cleared on reset, including
    // the operand and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            g_acc_q     <= 1'b0;
            p_acc_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            group_g_q   <= 1'b0;
            group_p_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= op_a;
                        b_q     <= sub ? ~op_b : op_b;
                        carry_q <= sub;
                        k_q     <= '0;
                        g_acc_q <= 1'b0;
                        p_acc_q <= 1'b1;
                    end
                end
                CALC: begin
                    a_q      <= a_q >> 4;
                    b_q      <= b_q >> 4;
                    result_q <= res_cat[WIDTH+3:4];
                    carry_q  <= carry_next;
                    g_acc_q  <= g_next;
                    p_acc_q  <= p_next;
                    if (k_q == K_LAST) begin
                        carry_out_q <= carry_next;
                        overflow_q  <= ovf_next;
                        group_g_q   <= g_next;
                        group_p_q   <= p_next;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign group_g   = group_g_q;
    assign group_p   = group_p_q;

endmodule
